quad_encoder_rpm: RTL and testbench
===================================

Name: quad_encoder_rpm

Overview:
- Parametrised successor to the single-channel rev counter; full x4 quadrature decoder fully inside the cclk domain.
- Synchronises raw A/B and decodes every A/B edge with sign.
- Tracks wrapping position and counts signed revolutions per fixed measurement window.
- Scales by gear ratio and publishes a saturated signed speed word with a valid strobe to the motor-control logic.

Parameters:
- CNT_W, 16, width of signed position counter
- RPM_W, 16, width of signed speed output and internal revolution counter
- GR_W, 8, width of unsigned gear-ratio input
- EDGES_PER_REV, 192, decoded x4 edges per motor revolution (48 A-rising edges x 4); must be >= 2
- WINDOW_CYCLES, 10000000, cclk cycles per measurement window; must be >= 4
- SYNC_STAGES, 2, flip-flops in each A/B input synchroniser; must be >= 2

Ports:
- cclk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- a  in  1  raw encoder channel A, asynchronous to cclk
- b  in  1  raw encoder channel B, asynchronous to cclk
- gr  in  GR_W  unsigned gear ratio, sampled at window end
- err_clr  in  1  clears err when high for one cycle
- pos  out  CNT_W  signed position, x4 edges
- rpm  out  RPM_W  signed, saturated speed: revolutions per window x gr
- rpm_valid  out  1  one-cycle pulse when rpm updates
- dir  out  1  0 = last valid step forward, 1 = reverse
- err  out  1  sticky illegal-transition flag

Behaviour:
- Reset: rst is asynchronous and active-high; all state clears immediately on assertion.
  - Reset values: pos=0, rpm=0, rpm_valid=0, dir=0, err=0.
  - Synchroniser flops, previous-state register, sub-rev accumulator, revolution counter, window counter and pipeline registers all clear to 0.
  - Reset mid-window discards that window; no rpm_valid is produced for it.
- Synchronisation and decode:
  - A and B each pass through SYNC_STAGES flops to give as/bs; s = {as,bs}; p = previous s.
  - Forward sequence 00->01->11->10->00 gives step +1.
  - Reverse sequence gives step -1.
  - s==p gives step 0.
  - Both bits changing in one cycle (00<->11, 01<->10) gives step 0 and sets err.
  - err stays high until err_clr. If err_clr and a new illegal transition occur in the same cycle, err stays 1.
- Position: pos += step, wrapping modulo 2^CNT_W. No saturation.
- dir: updated on every nonzero step (1 if step = -1); holds otherwise.
- Sub-revolution accumulator sub (range -(EDGES_PER_REV-1)..EDGES_PER_REV-1):
  - step +1 with sub==EDGES_PER_REV-1: sub<=0 and rev_win += 1.
  - step -1 with sub==-(EDGES_PER_REV-1): sub<=0 and rev_win -= 1.
  - Otherwise sub += step.
  - sub is NOT cleared at window end; partial revolutions carry into the next window.
- Window timer:
  - win_cnt counts 0..WINDOW_CYCLES-1, then wraps to 0 and starts again.
  - Terminal cycle T (win_cnt==WINDOW_CYCLES-1): rev_snap <= rev_win including any increment from T's own step; rev_win <= 0. Steps at T belong to the closing window.
  - rev_win width RPM_W; it wraps silently inside a window. Sizing parameters against maximum speed is the integrator's responsibility.
- Scaling pipeline:
  - At T+1: product = rev_snap (signed) x {0,gr} (signed, GR_W+1 bits), full-width signed result registered. gr is sampled at T+1.
  - At T+2: rpm <= product saturated to [-2^(RPM_W-1), 2^(RPM_W-1)-1]; rpm_valid=1 for exactly that one cycle.
  - Latency: rpm_valid occurs 2 cycles after the terminal cycle (e.g. a terminal cycle at 99 gives rpm_valid at 101).
  - rpm holds between updates.
- Decode latency: a raw edge that meets setup before cclk edge k changes pos after cclk edge k+SYNC_STAGES.

Test Plan (WINDOW_CYCLES=100, EDGES_PER_REV=4, SYNC_STAGES=2, RPM_W=8, gr=10 unless stated):
- Reset behaviour: assert rst asynchronously mid-window with A/B toggling -> all outputs 0 immediately. Release, apply no edges -> rpm_valid pulses every 100 cycles with rpm=0.
- Forward rotation: 12 forward Gray steps (3 revs) inside one window -> pos=12, dir=0, rpm=30 with rpm_valid at window terminal + 2. Next window with no motion -> rpm=0.
- Reverse rotation and wrap: reverse 8 steps -> pos=-8 (0xFFF8 for CNT_W=16), dir=1, rpm=-20. Repeat from pos=-32768 with one reverse step -> pos=32767.
- Residue carry: 2 forward steps in window N, 2 in window N+1 -> rpm=0 for N, rpm=10 for N+1. A step landing exactly on the terminal cycle counts in the closing window.
- Saturation: 20 revs per window with gr=10 -> rpm=127. Reverse 20 revs -> rpm=-128.
- Illegal transition: drive 00->11 -> err=1, pos unchanged. Pulse err_clr -> err=0. err_clr coincident with a new 01->10 -> err stays 1.

Source files
------------

// File: rtl/quad_encoder_rpm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : quad_encoder_rpm
// Purpose  : x4 quadrature decoder with wrapping position, per-window signed
//            revolution count scaled by gear ratio into a saturated speed word.
// Revision : 1.0 - initial release
// ============================================================================
module quad_encoder_rpm #(
  parameter int CNT_W         = 16,
  parameter int RPM_W         = 16,
  parameter int GR_W          = 8,
  parameter int EDGES_PER_REV = 192,
  parameter int WINDOW_CYCLES = 10000000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             cclk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic [GR_W-1:0]  gr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] pos,
  output logic [RPM_W-1:0] rpm,
  output logic             rpm_valid,
  output logic             dir,
  output logic             err
);

  localparam int SUB_W  = $clog2(EDGES_PER_REV) + 1;
  localparam int WIN_W  = $clog2(WINDOW_CYCLES);
  localparam int PROD_W = RPM_W + GR_W + 1;

  localparam logic signed [SUB_W-1:0]  c_sub_max  = SUB_W'(EDGES_PER_REV - 1);
  localparam logic signed [SUB_W-1:0]  c_sub_min  = SUB_W'(1 - EDGES_PER_REV);
  localparam logic        [WIN_W-1:0]  c_win_last = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic signed [PROD_W-1:0] c_rpm_max  = PROD_W'((2 ** (RPM_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] c_rpm_min  = ~c_rpm_max;

  logic [SYNC_STAGES-1:0]    r_a_sync, r_b_sync;
  logic [1:0]                r_prev;
  logic [CNT_W-1:0]          r_pos;
  logic                      r_dir, r_err;
  logic signed [SUB_W-1:0]   r_sub, w_sub_next;
  logic signed [RPM_W-1:0]   r_rev_win, w_rev_next, r_rev_snap;
  logic [WIN_W-1:0]          r_win_cnt;
  logic                      r_snap_vld;
  logic [RPM_W-1:0]          r_rpm, w_sat;
  logic                      r_rpm_valid;
  logic [1:0]                w_s, w_cur_idx, w_prev_idx, w_delta;
  logic                      w_fwd, w_rev, w_ill, w_term;
  logic signed [PROD_W-1:0]  w_prod;

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_a_sync <= '0;
      r_b_sync <= '0;
      r_prev   <= '0;
    end else begin
      r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], a};
      r_b_sync <= {r_b_sync[SYNC_STAGES-2:0], b};
      r_prev   <= w_s;
    end
  end

  // Gray phase to linear index (00,01,11,10 -> 0..3); index delta gives the step.
  assign w_s        = {r_a_sync[SYNC_STAGES-1], r_b_sync[SYNC_STAGES-1]};
  assign w_cur_idx  = {w_s[1], w_s[1] ^ w_s[0]};
  assign w_prev_idx = {r_prev[1], r_prev[1] ^ r_prev[0]};
  assign w_delta    = w_cur_idx - w_prev_idx;
  assign w_fwd      = (w_delta == 2'd1);
  assign w_rev      = (w_delta == 2'd3);
  assign w_ill      = (w_delta == 2'd2);
  assign w_term     = (r_win_cnt == c_win_last);

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_pos <= '0;
      r_dir <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_fwd) begin
        r_pos <= r_pos + CNT_W'(1);
        r_dir <= 1'b0;
      end else if (w_rev) begin
        r_pos <= r_pos - CNT_W'(1);
        r_dir <= 1'b1;
      end
      if (w_ill) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  always_comb begin
    w_sub_next = r_sub;
    w_rev_next = r_rev_win;
    if (w_fwd) begin
      if (r_sub == c_sub_max) begin
        w_sub_next = '0;
        w_rev_next = r_rev_win + RPM_W'(1);
      end else begin
        w_sub_next = r_sub + SUB_W'(1);
      end
    end else if (w_rev) begin
      if (r_sub == c_sub_min) begin
        w_sub_next = '0;
        w_rev_next = r_rev_win - RPM_W'(1);
      end else begin
        w_sub_next = r_sub - SUB_W'(1);
      end
    end
  end

  // The terminal cycle's own step is folded into the snapshot before clearing.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_sub      <= '0;
      r_rev_win  <= '0;
      r_rev_snap <= '0;
      r_win_cnt  <= '0;
      r_snap_vld <= 1'b0;
    end else begin
      r_sub      <= w_sub_next;
      r_snap_vld <= w_term;
      if (w_term) begin
        r_win_cnt  <= '0;
        r_rev_snap <= w_rev_next;
        r_rev_win  <= '0;
      end else begin
        r_win_cnt  <= r_win_cnt + WIN_W'(1);
        r_rev_win  <= w_rev_next;
      end
    end
  end

  assign w_prod = PROD_W'(r_rev_snap) * PROD_W'($signed({1'b0, gr}));

  always_comb begin
    w_sat = w_prod[RPM_W-1:0];
    if (w_prod > c_rpm_max) begin
      w_sat = c_rpm_max[RPM_W-1:0];
    end else if (w_prod < c_rpm_min) begin
      w_sat = c_rpm_min[RPM_W-1:0];
    end
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_rpm       <= '0;
      r_rpm_valid <= 1'b0;
    end else begin
      r_rpm_valid <= r_snap_vld;
      if (r_snap_vld) begin
        r_rpm <= w_sat;
      end
    end
  end

  assign pos       = r_pos;
  assign dir       = r_dir;
  assign err       = r_err;
  assign rpm       = r_rpm;
  assign rpm_valid = r_rpm_valid;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_rpm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_quad_encoder_rpm
// Purpose  : directed + random stimulus against a behavioural encoder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_rpm;

  localparam int CNT_W = 16;
  localparam int RPM_W = 8;
  localparam int GR_W  = 8;
  localparam int EPR   = 4;
  localparam int WIN   = 100;
  localparam int SYNC  = 2;

  logic             cclk = 1'b0;
  logic             rst = 1'b0;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             err_clr = 1'b0;
  logic [GR_W-1:0]  gr = 8'd10;
  logic [CNT_W-1:0] pos;
  logic [RPM_W-1:0] rpm;
  logic             rpm_valid, dir, err;

  quad_encoder_rpm #(
    .CNT_W(CNT_W), .RPM_W(RPM_W), .GR_W(GR_W),
    .EDGES_PER_REV(EPR), .WINDOW_CYCLES(WIN), .SYNC_STAGES(SYNC)
  ) dut (
    .cclk(cclk), .rst(rst), .a(a), .b(b), .gr(gr), .err_clr(err_clr),
    .pos(pos), .rpm(rpm), .rpm_valid(rpm_valid), .dir(dir), .err(err)
  );

  always #5 cclk = ~cclk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: forward Gray order, integer position/revolution bookkeeping.
  int seq [4] = '{0, 1, 3, 2};
  int q[$];
  int m_prev, m_pos, m_dir, m_err, m_sub, m_rev, m_win, m_snap, m_pend, m_rpm, m_vld;
  logic [1:0] cur = 2'b00;

  function automatic int gidx(input int v);
    for (int i = 0; i < 4; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  function automatic int wrap_rpm(input int r);
    int v;
    v = ((r % 256) + 256) % 256;
    if (v >= 128) v -= 256;
    return v;
  endfunction

  function automatic int sat_rpm(input int p);
    if (p > 127) return 127;
    if (p < -128) return -128;
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < SYNC; i++) q.push_back(0);
    m_prev = 0; m_pos = 0; m_dir = 0; m_err = 0; m_sub = 0; m_rev = 0;
    m_win = 0; m_snap = 0; m_pend = 0; m_rpm = 0; m_vld = 0;
  endtask

  task automatic model_edge();
    int c, d, st;
    q.push_back(int'({a, b}));
    c = q.pop_front();
    d = (gidx(c) - gidx(m_prev) + 4) % 4;
    st = (d == 1) ? 1 : (d == 3) ? -1 : 0;
    if (d == 2) m_err = 1;
    else if (err_clr) m_err = 0;
    m_prev = c;
    m_pos = (m_pos + st + 65536) % 65536;
    if (st != 0) m_dir = (st < 0) ? 1 : 0;
    if (st == 1 && m_sub == EPR - 1) begin m_sub = 0; m_rev++; end
    else if (st == -1 && m_sub == -(EPR - 1)) begin m_sub = 0; m_rev--; end
    else m_sub += st;
    m_vld = 0;
    if (m_pend != 0) begin
      m_rpm = sat_rpm(m_snap * int'(gr));
      m_vld = 1;
      m_pend = 0;
    end
    if (m_win == WIN - 1) begin
      m_snap = wrap_rpm(m_rev);
      m_rev = 0;
      m_pend = 1;
    end
    m_win = (m_win + 1) % WIN;
  endtask

  task automatic cyc(input logic [1:0] ab, input logic clr);
    @(negedge cclk);
    {a, b} = ab;
    err_clr = clr;
    @(posedge cclk);
    model_edge();
    #1;
    chk("pos", pos, m_pos);
    chk("dir", dir, m_dir);
    chk("err", err, m_err);
    chk("rpm_valid", rpm_valid, m_vld);
    chk("rpm", rpm, m_rpm & 255);
  endtask

  task automatic mv(input int s, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cur = 2'(seq[(gidx(int'(cur)) + s + 4) % 4]);
      cyc(cur, 1'b0);
      for (int j = 1; j < gap; j++) cyc(cur, 1'b0);
    end
  endtask

  task automatic align(input int w);
    int n;
    n = 0;
    while (m_win != w && n < 2 * WIN) begin
      cyc(cur, 1'b0);
      n++;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      cyc(cur, 1'b0);
      n++;
    end while (rpm_valid !== 1'b1 && n < 3 * WIN);
    chk({tag, "_seen"}, rpm_valid, 1);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_pos", pos, 0);
    chk("rst_rpm", rpm, 0);
    chk("rst_vld", rpm_valid, 0);
    chk("rst_dir", dir, 0);
    chk("rst_err", err, 0);
    repeat (3) begin
      @(negedge cclk);
      a = ~a;
      b = 1'($urandom_range(0, 1));
    end
    @(posedge cclk);
    #2;
    a = 1'b0; b = 1'b0; err_clr = 1'b0; cur = 2'b00;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, s;
    model_reset();
    #1 rst = 1'b1;
    #20;
    do_reset();

    // Idle windows: zero-speed updates every window.
    repeat (300) cyc(cur, 1'b0);

    align(0);
    mv(1, 12, 2);
    wait_valid("fwd");
    chk("fwd_rpm", rpm, 8'd30);
    chk("fwd_pos", pos, 16'd12);
    chk("fwd_dir", dir, 0);
    wait_valid("still");
    chk("still_rpm", rpm, 8'd0);

    // Asynchronous reset while moving mid-window.
    mv(1, 5, 1);
    do_reset();

    align(0);
    mv(-1, 8, 2);
    wait_valid("rev");
    chk("rev_rpm", rpm, 8'hEC);
    chk("rev_pos", pos, 16'hFFF8);
    chk("rev_dir", dir, 1);

    // Spin backwards through -32768 to wrap to +32767; speed saturates low.
    mv(-1, 32761, 1);
    cyc(cur, 1'b0);
    cyc(cur, 1'b0);
    chk("wrap_pos", pos, 16'h7FFF);
    chk("negsat_rpm", rpm, 8'h80);

    align(0);
    mv(1, 80, 1);
    wait_valid("sat");
    chk("sat_rpm", rpm, 8'h7F);

    // Partial revolutions carry across windows; terminal-cycle step counts.
    do_reset();
    align(0);
    mv(1, 2, 2);
    wait_valid("resN");
    chk("resN_rpm", rpm, 8'd0);
    mv(1, 2, 2);
    wait_valid("resN1");
    chk("resN1_rpm", rpm, 8'd10);
    align(WIN - 6);
    mv(1, 4, 1);
    wait_valid("term");
    chk("term_rpm", rpm, 8'd10);
    wait_valid("post");
    chk("post_rpm", rpm, 8'd0);

    // Illegal transitions and sticky error clearing.
    while (cur != 2'b00) mv(1, 1, 1);
    repeat (3) cyc(cur, 1'b0);
    mv(2, 1, 4);
    chk("ill_err", err, 1);
    cyc(cur, 1'b1);
    chk("clr_err", err, 0);
    mv(-1, 1, 4);
    cyc(2'b10, 1'b0);
    cyc(2'b10, 1'b0);
    cyc(2'b10, 1'b1);
    cur = 2'b10;
    chk("ill_clr_err", err, 1);
    cyc(cur, 1'b1);
    chk("clr2_err", err, 0);

    // Random motion, glitches, clears and gear changes.
    for (int i = 0; i < 5000; i++) begin
      if (i % 500 == 0)
        gr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'd10;
      r = $urandom_range(0, 99);
      s = (r < 35) ? 1 : (r < 60) ? -1 : (r < 62) ? 2 : 0;
      cur = 2'(seq[(gidx(int'(cur)) + s + 4) % 4]);
      cyc(cur, 1'($urandom_range(0, 24) == 0));
      if (i == 2500) begin
        gr = 8'd10;
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
